lsu_trigger_ctl: RTL and testbench
==================================

Name: lsu_trigger_ctl

Overview:
- Sequences LSU data/address trigger matches from the dc3 match stage down to commit (dc5).
- Applies chaining, mode/enable gating and flush kill to the matches.
- Generates the per-trigger hit-bit set pulses and the exception/debug-halt request toward dec/tlu.
- Sits between lsu_trigger (dc3 match vector) and the dec trigger CSR / debug logic.
- Owns a small halt-handshake FSM so a debug-action hit is held until debug acknowledges it.

Parameters:
- NTRIG, 4, number of triggers; pairs (0,1) and (2,3) are chainable. Only 4 is supported.
- CNT_W, 16, hit-counter width; used only with LSU_TRIG_HITCNT_EN.

Ports:
- clk  in  1  core clock
- rst_l  in  1  reset, asynchronous, active-low
- lsu_trigger_match_dc3  in  4  raw per-trigger match from the dc3 matcher
- lsu_valid_dc3  in  1  valid non-DMA LSU op in dc3
- trig_en  in  4  trigger enabled for the current privilege mode
- trig_chain  in  2  [0]: chain bit of trigger 0; [1]: chain bit of trigger 2
- trig_action  in  4  per trigger: 1 = enter debug, 0 = breakpoint exception
- flush_dc4  in  1  kill the op currently in dc4
- flush_dc5  in  1  kill the op currently in dc5
- dbg_mode  in  1  core in debug mode; suppresses all triggers
- dbg_halt_ack  in  1  debug has accepted the halt request
- dbg_resume  in  1  debug resumes the core
- lsu_trigger_match_dc5  out  4  final committed match vector
- lsu_trigger_hit_set  out  4  one-cycle pulse setting tdata1.hit
- lsu_trigger_exc_dc5  out  1  breakpoint exception request
- lsu_trigger_halt_req  out  1  debug halt request, level
- lsu_trigger_hitcnt  out  4*CNT_W  per-trigger hit counters

Behaviour:
- All outputs reset to 0. FSM resets to IDLE. All flops reset to 0.
- dc3 qualification: m3[i] = lsu_trigger_match_dc3[i] & lsu_valid_dc3 & trig_en[i] & ~dbg_mode & (state==IDLE).
- Chain rule, applied in dc3:
  - If trig_chain[0]=1: bits 0 and 1 are both set only if m3[0] & m3[1]; otherwise both are 0.
  - If trig_chain[1]=1: the same rule applies to bits 2 and 3.
  - If a chain bit is 0, each trigger in that pair stands alone.
- Pipeline:
  - dc4 register <= chained m3 every cycle.
  - dc5 register <= dc4 & ~{4{flush_dc4}}.
  - Latency dc3 -> dc5 is 2 cycles. There is no stall input; the pipeline advances every clk.
- dc5 outputs, combinational from the dc5 register:
  - v5 = dc5_reg & ~{4{flush_dc5}}.
  - lsu_trigger_match_dc5 = v5.
  - lsu_trigger_hit_set = v5, valid for exactly one cycle.
  - lsu_trigger_exc_dc5 = |(v5 & ~trig_action) & ~|(v5 & trig_action). A debug action takes priority over an exception.
- FSM states:
  - IDLE -> HALT_PEND when |(v5 & trig_action) in the current cycle.
  - HALT_PEND: lsu_trigger_halt_req=1. Goes to HALTED on dbg_halt_ack.
  - HALTED: halt_req=0. Goes to IDLE on dbg_resume.
  - Outside IDLE, new dc3 matches are suppressed. Entries already in dc4/dc5 still drain: they are reported and hit_set pulses, but they do not re-trigger the FSM.
  - If dbg_halt_ack and dbg_resume are asserted in the same cycle in HALT_PEND, the FSM goes to HALTED; resume is honoured only from HALTED.
  - dbg_halt_ack while in IDLE is ignored.
- Simultaneous flush_dc4 and flush_dc5 kill both entries independently.
- Async reset mid-handshake returns the FSM to IDLE with halt_req=0 immediately, not waiting for a clock edge.

Optional Feature:
- Macro: LSU_TRIG_HITCNT_EN.
- Defined:
  - Each trigger has a CNT_W-bit counter that increments on its lsu_trigger_hit_set pulse.
  - Counters saturate at all-ones and reset to 0.
  - lsu_trigger_hitcnt exposes the counters; trigger i occupies bits [i*CNT_W +: CNT_W].
- Not defined: lsu_trigger_hitcnt is tied to 0 and no counter flops exist.

Test Plan:
- Single match, no chain: match_dc3=4'b0001, valid=1, en=4'hF, action=0 -> 2 cycles later match_dc5=4'b0001, hit_set=4'b0001 for 1 cycle, exc=1, halt_req=0.
- Chain pair (0,1): trig_chain=2'b01.
  - match_dc3=4'b0001 -> match_dc5=0.
  - match_dc3=4'b0011 -> match_dc5=4'b0011.
- Flush kill:
  - match in dc3 with flush_dc4=1 on the next cycle -> match_dc5=0 and no hit_set.
  - Repeat with flush_dc5=1 in the dc5 cycle -> outputs 0.
- Halt handshake: action[2]=1, match bit 2 -> halt_req=1 from the cycle after dc5.
  - New matches during HALT_PEND produce no dc5 output.
  - dbg_halt_ack -> halt_req=0, state HALTED.
  - dbg_resume -> IDLE, and the next match is reported again.
- Mixed priority: match_dc3=4'b1001 with action=4'b1000 -> exc=0, halt_req=1, match_dc5=4'b1001.
- Reset/counters (LSU_TRIG_HITCNT_EN, CNT_W=2):
  - 5 hits on trigger 3 -> hitcnt[3]=2'b11, saturated.
  - rst_l pulled low while in HALT_PEND -> halt_req=0 and counters 0 before the next clk edge.

Source files
------------

// File: rtl/lsu_trigger_ctl.sv
// LSU trigger sequencer: qualifies and chains dc3 trigger matches, carries them to dc5, and raises the exception or debug-halt request.
// Optional per-trigger saturating hit counters are built when LSU_TRIG_HITCNT_EN is defined.
module lsu_trigger_ctl #(
  parameter int NTRIG = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic [NTRIG-1:0]       lsu_trigger_match_dc3,
  input  logic                   lsu_valid_dc3,
  input  logic [NTRIG-1:0]       trig_en,
  input  logic [1:0]             trig_chain,
  input  logic [NTRIG-1:0]       trig_action,
  input  logic                   flush_dc4,
  input  logic                   flush_dc5,
  input  logic                   dbg_mode,
  input  logic                   dbg_halt_ack,
  input  logic                   dbg_resume,
  output logic [NTRIG-1:0]       lsu_trigger_match_dc5,
  output logic [NTRIG-1:0]       lsu_trigger_hit_set,
  output logic                   lsu_trigger_exc_dc5,
  output logic                   lsu_trigger_halt_req,
  output logic [NTRIG*CNT_W-1:0] lsu_trigger_hitcnt
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] HALT_PEND = 2'd1;
  localparam logic [1:0] HALTED    = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [NTRIG-1:0] m3, m3_chained;
  logic [NTRIG-1:0] dc4_q, dc5_q;
  logic [NTRIG-1:0] v5;

  // New matches are only accepted while no halt handshake is in flight.
  assign m3 = lsu_trigger_match_dc3 & trig_en
            & {NTRIG{lsu_valid_dc3 & ~dbg_mode & (state == IDLE)}};

  always_comb begin
    m3_chained = m3;
    if (trig_chain[0]) m3_chained[1:0] = {2{m3[0] & m3[1]}};
    if (trig_chain[1]) m3_chained[3:2] = {2{m3[2] & m3[3]}};
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      dc4_q <= '0;
      dc5_q <= '0;
    end else begin
      dc4_q <= m3_chained;
      dc5_q <= dc4_q & ~{NTRIG{flush_dc4}};
    end
  end

  assign v5                    = dc5_q & ~{NTRIG{flush_dc5}};
  assign lsu_trigger_match_dc5 = v5;
  assign lsu_trigger_hit_set   = v5;
  // A debug-action hit anywhere in the vector overrides any breakpoint exception.
  assign lsu_trigger_exc_dc5   = (|(v5 & ~trig_action)) & ~(|(v5 & trig_action));
  assign lsu_trigger_halt_req  = (state == HALT_PEND);

  // Draining entries still report while not IDLE but cannot restart the handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (|(v5 & trig_action)) state_nxt = HALT_PEND;
      HALT_PEND: if (dbg_halt_ack)        state_nxt = HALTED;
      HALTED:    if (dbg_resume)          state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= IDLE;
    else        state <= state_nxt;
  end

`ifdef LSU_TRIG_HITCNT_EN
  logic [NTRIG*CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NTRIG; i++) begin
        if (v5[i] && (cnt_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}}))
          cnt_q[i*CNT_W +: CNT_W] <= cnt_q[i*CNT_W +: CNT_W] + 1'b1;
      end
    end
  end

  assign lsu_trigger_hitcnt = cnt_q;
`else
  assign lsu_trigger_hitcnt = '0;
`endif

endmodule

// File: tb/tb_lsu_trigger_ctl.sv
// Self-checking bench for lsu_trigger_ctl: directed scenarios plus random traffic against a behavioural model.
// Counter expectations follow LSU_TRIG_HITCNT_EN when it is defined for the build.
module tb_lsu_trigger_ctl;
  localparam int CNT_W = 2;
  localparam int CAP   = (1 << CNT_W) - 1;
`ifdef LSU_TRIG_HITCNT_EN
  localparam logic [CNT_W-1:0] SAT_EXP = {CNT_W{1'b1}};
`else
  localparam logic [CNT_W-1:0] SAT_EXP = '0;
`endif

  logic             clk = 1'b0;
  logic             rst_l = 1'b0;
  logic [3:0]       lsu_trigger_match_dc3 = '0;
  logic             lsu_valid_dc3 = 1'b0;
  logic [3:0]       trig_en = '0;
  logic [1:0]       trig_chain = '0;
  logic [3:0]       trig_action = '0;
  logic             flush_dc4 = 1'b0;
  logic             flush_dc5 = 1'b0;
  logic             dbg_mode = 1'b0;
  logic             dbg_halt_ack = 1'b0;
  logic             dbg_resume = 1'b0;
  logic [3:0]       lsu_trigger_match_dc5;
  logic [3:0]       lsu_trigger_hit_set;
  logic             lsu_trigger_exc_dc5;
  logic             lsu_trigger_halt_req;
  logic [4*CNT_W-1:0] lsu_trigger_hitcnt;

  lsu_trigger_ctl #(.NTRIG(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_l(rst_l),
    .lsu_trigger_match_dc3(lsu_trigger_match_dc3), .lsu_valid_dc3(lsu_valid_dc3),
    .trig_en(trig_en), .trig_chain(trig_chain), .trig_action(trig_action),
    .flush_dc4(flush_dc4), .flush_dc5(flush_dc5), .dbg_mode(dbg_mode),
    .dbg_halt_ack(dbg_halt_ack), .dbg_resume(dbg_resume),
    .lsu_trigger_match_dc5(lsu_trigger_match_dc5), .lsu_trigger_hit_set(lsu_trigger_hit_set),
    .lsu_trigger_exc_dc5(lsu_trigger_exc_dc5), .lsu_trigger_halt_req(lsu_trigger_halt_req),
    .lsu_trigger_hitcnt(lsu_trigger_hitcnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: the two in-flight stage contents and the debug handshake as plain flags.
  logic [3:0] q4, q5;
  bit         waiting_ack, halted;
  int         cnt[4];

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    q4 = '0; q5 = '0; waiting_ack = 0; halted = 0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
  endtask

  function automatic logic [4*CNT_W-1:0] model_hitcnt();
    logic [4*CNT_W-1:0] r;
    r = '0;
`ifdef LSU_TRIG_HITCNT_EN
    for (int i = 0; i < 4; i++) r[i*CNT_W +: CNT_W] = CNT_W'(cnt[i]);
`endif
    return r;
  endfunction

  // Advance the model by one clock using the inputs held across the edge.
  task automatic model_clock();
    logic [3:0] raw, m, v5;
    bit both;
    for (int i = 0; i < 4; i++)
      raw[i] = lsu_trigger_match_dc3[i] && lsu_valid_dc3 && trig_en[i] && !dbg_mode && !waiting_ack && !halted;
    m = raw;
    for (int p = 0; p < 2; p++) begin
      if (trig_chain[p]) begin
        both = raw[2*p] && raw[2*p+1];
        m[2*p] = both;
        m[2*p+1] = both;
      end
    end
    v5 = q5 & ~{4{flush_dc5}};
    for (int i = 0; i < 4; i++) if (v5[i] && cnt[i] < CAP) cnt[i]++;
    if (waiting_ack) begin
      if (dbg_halt_ack) begin waiting_ack = 0; halted = 1; end
    end else if (halted) begin
      if (dbg_resume) halted = 0;
    end else if ((v5 & trig_action) != 0) begin
      waiting_ack = 1;
    end
    q5 = flush_dc4 ? 4'b0 : q4;
    q4 = m;
  endtask

  task automatic begin_cycle();
    @(negedge clk);
    lsu_trigger_match_dc3 = '0; lsu_valid_dc3 = 1'b1;
    flush_dc4 = 1'b0; flush_dc5 = 1'b0; dbg_mode = 1'b0;
    dbg_halt_ack = 1'b0; dbg_resume = 1'b0;
  endtask

  task automatic check_model();
    logic [3:0] v5;
    bit any_dbg, any_exc;
    #1;
    v5 = q5 & ~{4{flush_dc5}};
    any_dbg = (v5 & trig_action) != 0;
    any_exc = (v5 & ~trig_action) != 0;
    check_output("match_dc5", 64'(lsu_trigger_match_dc5), 64'(v5));
    check_output("hit_set", 64'(lsu_trigger_hit_set), 64'(v5));
    check_output("exc_dc5", 64'(lsu_trigger_exc_dc5), 64'(any_exc && !any_dbg));
    check_output("halt_req", 64'(lsu_trigger_halt_req), 64'(waiting_ack));
    check_output("hitcnt", 64'(lsu_trigger_hitcnt), 64'(model_hitcnt()));
  endtask

  task automatic end_cycle();
    @(posedge clk);
    model_clock();
  endtask

  task automatic apply_stimulus(input logic [3:0] m);
    begin_cycle(); lsu_trigger_match_dc3 = m; check_model(); end_cycle();
  endtask

  // Launch a match and leave the caller sampling its dc5 cycle.
  task automatic send_to_dc5(input logic [3:0] m);
    apply_stimulus(m);
    apply_stimulus(4'b0);
    begin_cycle(); check_model();
  endtask

  initial begin
    model_reset();
    #2;
    check_output("rst_match", 64'(lsu_trigger_match_dc5), 64'h0);
    check_output("rst_hit", 64'(lsu_trigger_hit_set), 64'h0);
    check_output("rst_exc", 64'(lsu_trigger_exc_dc5), 64'h0);
    check_output("rst_halt", 64'(lsu_trigger_halt_req), 64'h0);
    check_output("rst_hitcnt", 64'(lsu_trigger_hitcnt), 64'h0);
    @(posedge clk); @(posedge clk); #2 rst_l = 1'b1;
    trig_en = 4'hF; trig_chain = 2'b00; trig_action = 4'b0000;

    send_to_dc5(4'b0001);
    check_output("single_match", 64'(lsu_trigger_match_dc5), 64'h1);
    check_output("single_exc", 64'(lsu_trigger_exc_dc5), 64'h1);
    check_output("single_halt", 64'(lsu_trigger_halt_req), 64'h0);
    end_cycle();
    begin_cycle(); check_model();
    check_output("single_pulse_end", 64'(lsu_trigger_hit_set), 64'h0);
    end_cycle();

    trig_chain = 2'b01;
    send_to_dc5(4'b0001);
    check_output("chain_half", 64'(lsu_trigger_match_dc5), 64'h0);
    end_cycle();
    send_to_dc5(4'b0011);
    check_output("chain_full", 64'(lsu_trigger_match_dc5), 64'h3);
    end_cycle();
    trig_chain = 2'b00;

    apply_stimulus(4'b0010);
    begin_cycle(); flush_dc4 = 1'b1; check_model(); end_cycle();
    begin_cycle(); check_model();
    check_output("flush4_match", 64'(lsu_trigger_match_dc5), 64'h0);
    check_output("flush4_hit", 64'(lsu_trigger_hit_set), 64'h0);
    end_cycle();
    apply_stimulus(4'b0010);
    apply_stimulus(4'b0000);
    begin_cycle(); flush_dc5 = 1'b1; check_model();
    check_output("flush5_match", 64'(lsu_trigger_match_dc5), 64'h0);
    check_output("flush5_exc", 64'(lsu_trigger_exc_dc5), 64'h0);
    end_cycle();

    trig_action = 4'b0100;
    send_to_dc5(4'b0100);
    check_output("halt_dc5_match", 64'(lsu_trigger_match_dc5), 64'h4);
    check_output("halt_dc5_exc", 64'(lsu_trigger_exc_dc5), 64'h0);
    end_cycle();
    begin_cycle(); lsu_trigger_match_dc3 = 4'b0100; check_model();
    check_output("halt_req_set", 64'(lsu_trigger_halt_req), 64'h1);
    end_cycle();
    apply_stimulus(4'b0100);
    begin_cycle(); check_model();
    check_output("halt_suppress", 64'(lsu_trigger_match_dc5), 64'h0);
    end_cycle();
    begin_cycle(); dbg_halt_ack = 1'b1; check_model(); end_cycle();
    begin_cycle(); check_model();
    check_output("halted_req", 64'(lsu_trigger_halt_req), 64'h0);
    end_cycle();
    begin_cycle(); dbg_resume = 1'b1; check_model(); end_cycle();
    send_to_dc5(4'b0100);
    check_output("resume_match", 64'(lsu_trigger_match_dc5), 64'h4);
    end_cycle();
    begin_cycle(); dbg_halt_ack = 1'b1; dbg_resume = 1'b1; check_model(); end_cycle();
    apply_stimulus(4'b0100);
    apply_stimulus(4'b0000);
    begin_cycle(); check_model();
    check_output("ack_resume_same", 64'(lsu_trigger_match_dc5), 64'h0);
    end_cycle();
    begin_cycle(); dbg_resume = 1'b1; check_model(); end_cycle();

    trig_action = 4'b1000;
    send_to_dc5(4'b1001);
    check_output("mixed_match", 64'(lsu_trigger_match_dc5), 64'h9);
    check_output("mixed_exc", 64'(lsu_trigger_exc_dc5), 64'h0);
    end_cycle();
    begin_cycle(); check_model();
    check_output("mixed_halt", 64'(lsu_trigger_halt_req), 64'h1);
    end_cycle();
    begin_cycle(); dbg_halt_ack = 1'b1; check_model(); end_cycle();
    begin_cycle(); dbg_resume = 1'b1; check_model(); end_cycle();

    trig_action = 4'b0000;
    for (int k = 0; k < 5; k++) apply_stimulus(4'b1000);
    apply_stimulus(4'b0000);
    begin_cycle(); check_model();
    check_output("cnt_sat", 64'(lsu_trigger_hitcnt[3*CNT_W +: CNT_W]), 64'(SAT_EXP));
    end_cycle();

    trig_action = 4'b0100;
    send_to_dc5(4'b0100);
    end_cycle();
    begin_cycle(); check_model();
    check_output("pre_reset_halt", 64'(lsu_trigger_halt_req), 64'h1);
    #2 rst_l = 1'b0;
    #1;
    check_output("async_rst_halt", 64'(lsu_trigger_halt_req), 64'h0);
    check_output("async_rst_cnt", 64'(lsu_trigger_hitcnt), 64'h0);
    check_output("async_rst_match", 64'(lsu_trigger_match_dc5), 64'h0);
    @(posedge clk);
    model_reset();
    #2 rst_l = 1'b1;

    for (int n = 0; n < 600; n++) begin
      begin_cycle();
      lsu_trigger_match_dc3 = 4'($urandom);
      lsu_valid_dc3 = ($urandom % 8) != 0;
      trig_en = (($urandom % 4) == 0) ? 4'($urandom) : 4'hF;
      trig_chain = 2'($urandom);
      trig_action = 4'($urandom);
      flush_dc4 = ($urandom % 7) == 0;
      flush_dc5 = ($urandom % 7) == 0;
      dbg_mode = ($urandom % 16) == 0;
      dbg_halt_ack = ($urandom % 4) == 0;
      dbg_resume = ($urandom % 5) == 0;
      check_model();
      end_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
